// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU normalize/pack stage.
//   Float layout: sign[31] | biased exponent[30:21] (bias 511) | fraction[20:0]
//   Exports the width constants, FSM state and status encodings and field positions.
package fpu_pkg;

  localparam int EXP_W   = 10;
  localparam int FRAC_W  = 21;
  localparam int BIAS    = 511;
  localparam int MANT_W  = 25;   // 2 carry bits, hidden bit, 21 fraction bits, guard
  localparam int IEXP_W  = 12;   // internal signed exponent width

  localparam int SIGN_POS = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 21;
  localparam int FRAC_HI  = 20;

  localparam logic [EXP_W-1:0] EXP_INF = '1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, PACK} state_t;

  typedef enum logic [1:0] {ST_EXACT, ST_INEXACT, ST_OVERFLOW, ST_UNDERFLOW} status_t;

endpackage

// File: rtl/fpu_round_ne.sv
// Combinational round-to-nearest-even on a stored fraction.
//   frac     : fraction bits before rounding
//   guard    : first bit below the fraction LSB
//   sticky   : OR of every bit shifted out below the guard
//   frac_rnd : rounded fraction (wraps to 0 when carry is set)
//   carry    : rounding overflowed the fraction into the hidden-bit position
//   inexact  : any nonzero bit was discarded
module fpu_round_ne
  import fpu_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac_rnd,
  output logic              carry,
  output logic              inexact
);

  logic round_up;

  // Ties (guard set, sticky clear) round up only when the LSB is odd.
  assign round_up = guard & (sticky | frac[0]);
  assign {carry, frac_rnd} = {1'b0, frac} + (FRAC_W+1)'(round_up);
  assign inexact = guard | sticky;

endmodule

// File: rtl/fpu_normalize_pack.sv
// Iterative normalize, round and pack of an add/sub result.
//   clock_100Khz : system clock, rising edge
//   reset        : asynchronous, active-low
//   start_in     : one-cycle request, taken only in IDLE
//   sign_in      : result sign
//   exp_in       : signed unbiased exponent
//   mant_in      : magnitude, bit22 = hidden bit, bits[24:23] carry, bit0 guard
//   busy_out     : high while an operation is in flight
//   done_out     : one-cycle pulse when data_out/status_out update
//   data_out     : packed float, held until the next done
//   status_out   : EXACT / INEXACT / OVERFLOW / UNDERFLOW
//
// state | meaning
// IDLE  | waiting for start_in
// NORM  | one normalizing shift per cycle until bit22 is the leading one
// ROUND | round to nearest even, renormalize on carry-out
// PACK  | range check, register result, pulse done
module fpu_normalize_pack
  import fpu_pkg::*;
(
  input  logic              clock_100Khz,
  input  logic              reset,
  input  logic              start_in,
  input  logic              sign_in,
  input  logic [10:0]       exp_in,
  input  logic [MANT_W-1:0] mant_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [31:0]       data_out,
  output logic [1:0]        status_out
);

  state_t                    state;
  logic                      sign_r;
  logic signed [IEXP_W-1:0]  exp_r;
  logic [MANT_W-1:0]         mant_r;
  logic                      sticky_r;
  logic                      inexact_r;

  logic [FRAC_W-1:0]         rnd_frac;
  logic                      rnd_carry;
  logic                      rnd_inexact;
  logic signed [IEXP_W-1:0]  biased;

  fpu_round_ne u_round (
    .frac     (mant_r[FRAC_W:1]),
    .guard    (mant_r[0]),
    .sticky   (sticky_r),
    .frac_rnd (rnd_frac),
    .carry    (rnd_carry),
    .inexact  (rnd_inexact)
  );

  assign biased = exp_r + $signed(IEXP_W'(BIAS));

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sign_r     <= 1'b0;
      exp_r      <= '0;
      mant_r     <= '0;
      sticky_r   <= 1'b0;
      inexact_r  <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      data_out   <= '0;
      status_out <= ST_EXACT;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            sign_r   <= sign_in;
            exp_r    <= {exp_in[10], exp_in};
            mant_r   <= mant_in;
            sticky_r <= 1'b0;
            busy_out <= 1'b1;
            state    <= NORM;
          end
        end
        NORM: begin
          if (mant_r == '0) begin
            state <= ROUND;
          end else if (mant_r[24] | mant_r[23]) begin
            mant_r   <= mant_r >> 1;
            sticky_r <= sticky_r | mant_r[0];
            exp_r    <= exp_r + 12'sd1;
          end else if (!mant_r[22]) begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_r - 12'sd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          inexact_r <= rnd_inexact;
          // A carry out of the fraction means the mantissa became 2.0; the
          // renormalized fraction is all zeros with the hidden bit set.
          if (rnd_carry) begin
            mant_r <= {2'b00, 1'b1, {FRAC_W{1'b0}}, 1'b0};
            exp_r  <= exp_r + 12'sd1;
          end else begin
            mant_r <= {2'b00, mant_r[22], rnd_frac, 1'b0};
          end
          state <= PACK;
        end
        PACK: begin
          if (mant_r == '0) begin
            data_out   <= {sign_r, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
            status_out <= ST_EXACT;
          end else if (biased >= 12'sd1023) begin
            data_out   <= {sign_r, EXP_INF, {FRAC_W{1'b0}}};
            status_out <= ST_OVERFLOW;
          end else if (biased <= 12'sd0) begin
            data_out   <= {sign_r, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
            status_out <= ST_UNDERFLOW;
          end else begin
            data_out   <= {sign_r, biased[EXP_W-1:0], mant_r[FRAC_W:1]};
            status_out <= inexact_r ? ST_INEXACT : ST_EXACT;
          end
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_normalize_pack.sv
`timescale 1ns/1ps
module tb_fpu_normalize_pack;

  logic        clock_100Khz;
  logic        reset;
  logic        start_in;
  logic        sign_in;
  logic [10:0] exp_in;
  logic [24:0] mant_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] data_out;
  logic [1:0]  status_out;

  int tests = 0;
  int fails = 0;

  fpu_normalize_pack dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .start_in     (start_in),
    .sign_in      (sign_in),
    .exp_in       (exp_in),
    .mant_in      (mant_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .data_out     (data_out),
    .status_out   (status_out)
  );

  initial clock_100Khz = 1'b0;
  always #5 clock_100Khz = ~clock_100Khz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation and follow it to done. Edge 1 is the acceptance edge;
  // done must appear after edge exp_lat, with busy high on the samples before it.
  task automatic run_op(input string tag, input logic s, input logic [10:0] e,
                        input logic [24:0] m, input logic [31:0] exp_d,
                        input logic [1:0] exp_st, input int exp_lat,
                        input bit extra_start);
    int n;
    int busy_cnt;
    bit seen;
    n = 0;
    busy_cnt = 0;
    seen = 0;
    @(negedge clock_100Khz);
    sign_in  = s;
    exp_in   = e;
    mant_in  = m;
    start_in = 1'b1;
    while (!seen && n < 60) begin
      @(posedge clock_100Khz);
      #1;
      n++;
      start_in = 1'b0;
      if (extra_start && n == 2) begin
        start_in = 1'b1;
        sign_in  = 1'b1;
        exp_in   = 11'd5;
        mant_in  = 25'h0400000;
      end
      if (done_out) seen = 1;
      else if (busy_out) busy_cnt++;
    end
    start_in = 1'b0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    check({tag, " data"}, data_out, exp_d);
    check({tag, " status"}, {30'd0, status_out}, {30'd0, exp_st});
    @(posedge clock_100Khz);
    #1;
    check({tag, " done_one_cycle"}, {31'd0, done_out}, 32'd0);
    check({tag, " data_held"}, data_out, exp_d);
  endtask

  initial begin
    int dones;
    reset    = 1'b0;
    start_in = 1'b0;
    sign_in  = 1'b0;
    exp_in   = '0;
    mant_in  = '0;
    #12;
    check("rst busy", {31'd0, busy_out}, 32'd0);
    check("rst done", {31'd0, done_out}, 32'd0);
    check("rst data", data_out, 32'd0);
    check("rst status", {30'd0, status_out}, 32'd0);
    @(negedge clock_100Khz);
    reset = 1'b1;

    run_op("one",      1'b0, 11'd0,    25'h0400000, 32'h3FE00000, 2'd0, 4,  0);
    run_op("neg6",     1'b1, 11'd0,    25'h1800000, 32'hC0300000, 2'd0, 6,  0);
    run_op("pow_m12",  1'b0, 11'd0,    25'h0000400, 32'h3E600000, 2'd0, 16, 0);
    run_op("rnd_carry",1'b0, 11'd0,    25'h07FFFFF, 32'h40000000, 2'd1, 4,  0);
    run_op("tie_even", 1'b0, 11'd0,    25'h0400001, 32'h3FE00000, 2'd1, 4,  0);
    run_op("sticky",   1'b1, 11'd0,    25'h1800001, 32'hC0300000, 2'd1, 6,  0);
    run_op("ovf",      1'b0, 11'd512,  25'h0400000, 32'h7FE00000, 2'd2, 4,  0);
    run_op("unf",      1'b0, 11'h601,  25'h0400000, 32'h00000000, 2'd3, 4,  0);
    run_op("neg_zero", 1'b1, 11'd0,    25'h0000000, 32'h80000000, 2'd0, 4,  0);
    run_op("ign_start",1'b0, 11'd0,    25'h0000400, 32'h3E600000, 2'd0, 16, 1);

    // Abort the 2^-12 case in the middle of normalization.
    @(negedge clock_100Khz);
    sign_in  = 1'b0;
    exp_in   = 11'd0;
    mant_in  = 25'h0000400;
    start_in = 1'b1;
    @(posedge clock_100Khz);
    #1;
    start_in = 1'b0;
    repeat (5) @(posedge clock_100Khz);
    #2;
    check("abort busy_before", {31'd0, busy_out}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy_out}, 32'd0);
    check("abort done", {31'd0, done_out}, 32'd0);
    check("abort data", data_out, 32'd0);
    check("abort status", {30'd0, status_out}, 32'd0);
    @(negedge clock_100Khz);
    reset = 1'b1;
    dones = 0;
    repeat (30) begin
      @(posedge clock_100Khz);
      #1;
      if (done_out) dones++;
    end
    check("abort no_done", dones, 0);
    check("abort idle_busy", {31'd0, busy_out}, 32'd0);

    run_op("after_abort", 1'b0, 11'd0, 25'h0400000, 32'h3FE00000, 2'd0, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_normalize_pack.md
Name: fpu_normalize_pack

Overview:
Downstream stage of the FPU arithmetic core. It takes the unnormalized signed-magnitude result of an add/sub (sign, unbiased exponent, wide mantissa with guard/sticky) and normalizes it iteratively, one shift per cycle. It rounds to nearest-even and packs the result into the team's 32-bit float format: sign[31], biased exponent[30:21] (bias 511), fraction[20:0]. It also reports a result status code.

Parameters:
EXP_W, 10, biased exponent width
FRAC_W, 21, stored fraction width
BIAS, 511, exponent bias (2^(EXP_W-1)-1)

Ports:
clock_100Khz  in  1  system clock, 100 kHz; all state on rising edge
reset  in  1  asynchronous, active-low reset
start_in  in  1  one-cycle request; sampled only in IDLE
sign_in  in  1  result sign
exp_in  in  11  signed two's-complement unbiased exponent
mant_in  in  25  unsigned magnitude; value = mant_in/2^22 * 2^exp_in; bit22 = hidden-bit position, bits[24:23] = carry, bit0 = guard
busy_out  out  1  high from the cycle after start acceptance until done
done_out  out  1  one-cycle pulse; data_out/status_out valid from this cycle
data_out  out  32  packed result; held until the next done
status_out  out  2  0 EXACT, 1 INEXACT, 2 OVERFLOW, 3 UNDERFLOW; held with data_out

Behaviour:
- Reset (async, reset=0): state IDLE; busy_out=0, done_out=0, data_out=0, status_out=0; internal mant/exp/sticky cleared. Reset mid-operation aborts the operation, and no done is produced.
- FSM: IDLE -> NORM -> ROUND -> PACK -> IDLE.
- IDLE: on start_in=1, latch sign, exp (sign-extended to 12 bits internal), mant; sticky=0; go NORM. start_in is ignored in any other state.
- NORM, one action per cycle, in priority order:
  - mant==0: go ROUND (zero path).
  - mant[24]|mant[23]: right shift 1, sticky |= mant[0], exp+1.
  - !mant[22]: left shift 1, exp-1.
  - otherwise: go ROUND.
- ROUND (one cycle): frac=mant[21:1], guard=mant[0].
  - Round up if guard & (sticky | frac[0]).
  - Inexact = guard | sticky.
  - If rounding carries into bit23: shift right 1 and exp+1, all in the same cycle.
- PACK (one cycle): biased = exp+BIAS, 12-bit signed.
  - mant==0: data = {sign, 0, 0}; EXACT.
  - biased >= 1023: data = {sign, 10'h3FF, 0} (infinity); OVERFLOW.
  - biased <= 0: data = {sign, 0, 0} (flush to zero); UNDERFLOW.
  - else: data = {sign, biased[9:0], frac}; INEXACT if inexact, otherwise EXACT.
  - Register data_out and status_out, pulse done_out, drop busy_out, go IDLE.
- Latency: start edge to done = 4 cycles + number of NORM shifts. Maximum shifts: 2 right or 22 left.
- Simultaneous start_in with the done cycle: not accepted. The FSM is in PACK on that edge; start is taken only in IDLE.
- Exponent range checks are made only in PACK; internal 12-bit exp cannot wrap for legal inputs.

Decomposition:
- Shared package fpu_pkg:
  - EXP_W, FRAC_W, BIAS constants.
  - State enum {IDLE, NORM, ROUND, PACK}.
  - Status enum {ST_EXACT, ST_INEXACT, ST_OVERFLOW, ST_UNDERFLOW}.
  - Packed-float field positions.
- Optional sub-module fpu_round_ne: combinational round-to-nearest-even on {frac, guard, sticky}, producing rounded frac, carry and inexact. Everything else stays in one module.

Test Plan:
- mant_in=0x0400000, exp_in=0, sign=0 -> data_out=0x3FE00000, EXACT; done 4 cycles after start; busy high for 3 cycles.
- mant_in=0x1800000, exp_in=0, sign=1 (-6.0) -> 2 right shifts; data_out=0xC0300000, EXACT; done at cycle 6.
- mant_in=0x0000400, exp_in=0 (2^-12) -> 12 left shifts; data_out=0x3E600000, EXACT; done at cycle 16.
- mant_in=0x07FFFFF, exp_in=0 (tie, odd LSB) -> round-up carry; data_out=0x40000000, INEXACT.
- exp_in=+512 with mant=0x0400000 -> 0x7FE00000, OVERFLOW. exp_in=-511 -> 0x00000000, UNDERFLOW. mant=0 with sign=1 -> 0x80000000, EXACT.
- Assert reset during NORM of the 2^-12 case -> all outputs 0 immediately, no done. A start_in pulse during busy in a separate run is ignored, and the first result is unaffected.
